// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and widths.
// Imported by the fetch unit and its FIFO users.
package fetch_pkg;

    localparam int PC_WIDTH    = 9;
    localparam int INSTR_WIDTH = 32;
    localparam int PC_STEP     = 4;

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
        logic [PC_WIDTH-1:0]    pc;
    } fetch_entry_t;

    // Sequential PC; wraps naturally at the PC width.
    function automatic logic [PC_WIDTH-1:0] pc_inc(
        input logic [PC_WIDTH-1:0] cur
    );
        return cur + PC_WIDTH'(PC_STEP);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with flush and occupancy count.
// DEPTH must be a power of two so pointers wrap for free.
module sync_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  T              wdata,
    input  logic          pop,
    input  logic          flush,
    output T              rdata,
    output logic [CW-1:0] count,
    output logic          empty
);

    T              mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;
    logic          full;

    assign do_push = push && !flush;
    assign do_pop  = pop && !flush;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; empty masks stale words.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

    a_no_overflow: assert property (
        @(posedge clk) disable iff (reset)
        !(push && !flush && full)
    );

    a_no_underflow: assert property (
        @(posedge clk) disable iff (reset)
        !(pop && !flush && empty)
    );

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-gated requests, PC mux,
// in-flight tracking and a tagged instruction FIFO.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [PC_WIDTH-1:0]    pc,
    output logic [PC_WIDTH-1:0]    pc_next,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   redirect,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   instr_valid,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [PC_WIDTH-1:0]    instr_pc,
    input  logic                   instr_ready
);

    localparam int CW = $clog2(DEPTH + 1);

    logic                inflight_q;
    logic [PC_WIDTH-1:0] inflight_pc_q;
    logic [CW-1:0]       count;
    logic [CW:0]         used;
    logic                empty;
    logic                push;
    logic                pop;
    fetch_entry_t        wr_entry;
    fetch_entry_t        head;

    // Credit ignores this cycle's pop: no ready-to-req path.
    assign used     = {1'b0, count} + (CW + 1)'(inflight_q);
    assign imem_req = !reset && !redirect
                    && (used < (CW + 1)'(DEPTH));
    assign imem_addr = pc;

    always_comb begin
        pc_next = pc;
        unique case (1'b1)
            redirect: pc_next = redirect_pc;
            imem_req: pc_next = pc_inc(pc);
            default:  pc_next = pc;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            inflight_q <= imem_req;
            if (imem_req)
                inflight_pc_q <= pc;
        end
    end

    // A response landing in a redirect cycle is dropped.
    assign push     = inflight_q && !redirect;
    assign pop      = instr_valid && instr_ready && !redirect;
    assign wr_entry = '{instr: imem_rdata, pc: inflight_pc_q};

    sync_fifo #(
        .T     (fetch_entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (wr_entry),
        .pop   (pop),
        .flush (redirect),
        .rdata (head),
        .count (count),
        .empty (empty)
    );

    assign instr_valid = !empty;
    assign instr       = instr_valid ? head.instr : '0;
    assign instr_pc    = instr_valid ? head.pc : '0;

    a_credit: assert property (
        @(posedge clk) disable iff (reset)
        used <= (CW + 1)'(DEPTH)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed table,
// hand sequences and randomized run against a queue model.
module tb_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [8:0]  pc;
    logic [8:0]  pc_next;
    logic        imem_req;
    logic [8:0]  imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [8:0]  redirect_pc = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [8:0]  instr_pc;
    logic        instr_ready = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_unit #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .pc_next     (pc_next),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    function automatic logic [31:0] memf(input logic [8:0] a);
        return {23'd0, a} * 32'd16;
    endfunction

    // PC register and synchronous instruction memory
    always @(posedge clk or posedge reset)
        if (reset) pc <= '0;
        else       pc <= pc_next;

    always @(posedge clk)
        if (imem_req) imem_rdata <= memf(imem_addr);

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: queue of presented words, pending read
    typedef struct {
        logic [31:0] i;
        logic [8:0]  p;
    } ent_t;

    ent_t       mq[$];
    ent_t       mpend[$];
    logic [8:0] mpc = '0;

    task automatic step(input logic r, input logic rd,
                        input logic [8:0] rpc, input logic rdy);
        logic       e_valid;
        logic       e_req;
        logic [8:0] e_next;
        reset = r;
        redirect = rd;
        redirect_pc = rpc;
        instr_ready = rdy;
        #1;
        if (r) begin
            mq.delete();
            mpend.delete();
            mpc = '0;
        end
        e_valid = (mq.size() > 0);
        e_req = !r && !rd && (mq.size() + mpend.size() < DEPTH);
        e_next = rd ? rpc : (e_req ? 9'(mpc + 9'd4) : mpc);
        chk("instr_valid", instr_valid, e_valid);
        if (e_valid) begin
            chk("instr_pc", instr_pc, mq[0].p);
            chk("instr", instr, mq[0].i);
        end
        chk("imem_req", imem_req, e_req);
        chk("imem_addr", imem_addr, mpc);
        if (!r) chk("pc_next", pc_next, e_next);
        if (!r) begin
            if (rd) begin
                mq.delete();
                mpend.delete();
            end else begin
                if (e_valid && rdy) void'(mq.pop_front());
                if (mpend.size() > 0) begin
                    mq.push_back(mpend[0]);
                    mpend.delete();
                end
            end
            if (e_req) mpend.push_back('{memf(mpc), mpc});
            mpc = e_next;
        end
        @(posedge clk);
        #1;
        redirect = 1'b0;
        #1;
    endtask

    typedef struct {
        logic       rdy;
        logic       req;
        logic [8:0] addr;
        logic       valid;
        logic [8:0] ipc;
    } vec_t;

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 9'h000, 1'b0, 9'h000};
        tbl[1]  = '{1'b0, 1'b1, 9'h004, 1'b0, 9'h000};
        tbl[2]  = '{1'b0, 1'b1, 9'h008, 1'b1, 9'h000};
        tbl[3]  = '{1'b0, 1'b1, 9'h00C, 1'b1, 9'h000};
        tbl[4]  = '{1'b0, 1'b0, 9'h010, 1'b1, 9'h000};
        tbl[5]  = '{1'b0, 1'b0, 9'h010, 1'b1, 9'h000};
        tbl[6]  = '{1'b1, 1'b0, 9'h010, 1'b1, 9'h000};
        tbl[7]  = '{1'b1, 1'b1, 9'h010, 1'b1, 9'h004};
        tbl[8]  = '{1'b1, 1'b1, 9'h014, 1'b1, 9'h008};
        tbl[9]  = '{1'b1, 1'b1, 9'h018, 1'b1, 9'h00C};
        tbl[10] = '{1'b1, 1'b1, 9'h01C, 1'b1, 9'h010};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 9'h0);
        chk("rst_req", imem_req, 1'b0);
        chk("rst_addr", imem_addr, 9'h0);

        // Stall from reset, then drain
        step(1'b1, 1'b0, 9'h0, 1'b0);
        for (int k = 0; k < 11; k++) begin
            reset = 1'b0;
            instr_ready = tbl[k].rdy;
            #1;
            chk("tbl_req", imem_req, tbl[k].req);
            chk("tbl_addr", imem_addr, tbl[k].addr);
            chk("tbl_valid", instr_valid, tbl[k].valid);
            if (tbl[k].valid)
                chk("tbl_instr_pc", instr_pc, tbl[k].ipc);
            step(1'b0, 1'b0, 9'h0, tbl[k].rdy);
        end

        // Streaming from reset: valid two cycles after first req
        step(1'b1, 1'b0, 9'h0, 1'b1);
        for (int c = 0; c < 5; c++) begin
            if (c < 2) chk("stream_valid_lo", instr_valid, 1'b0);
            else       chk("stream_pc", instr_pc, 9'((c - 2) * 4));
            step(1'b0, 1'b0, 9'h0, 1'b1);
        end

        // Redirect with two entries buffered and one in flight
        step(1'b1, 1'b0, 9'h0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 9'h0, 1'b0);
        step(1'b0, 1'b1, 9'h100, 1'b0);
        chk("redir_r1_valid", instr_valid, 1'b0);
        chk("redir_r1_req", imem_req, 1'b1);
        chk("redir_r1_addr", imem_addr, 9'h100);
        step(1'b0, 1'b0, 9'h0, 1'b1);
        chk("redir_r2_valid", instr_valid, 1'b0);
        step(1'b0, 1'b0, 9'h0, 1'b1);
        chk("redir_r3_valid", instr_valid, 1'b1);
        chk("redir_r3_pc", instr_pc, 9'h100);
        chk("redir_r3_instr", instr, 32'h1000);

        // Redirect colliding with a response and a pop
        repeat (4) step(1'b0, 1'b0, 9'h0, 1'b1);
        step(1'b0, 1'b1, 9'h040, 1'b1);
        chk("coll_r1_valid", instr_valid, 1'b0);
        step(1'b0, 1'b0, 9'h0, 1'b1);
        step(1'b0, 1'b0, 9'h0, 1'b1);
        chk("coll_pc0", instr_pc, 9'h040);
        step(1'b0, 1'b0, 9'h0, 1'b1);
        chk("coll_pc1", instr_pc, 9'h044);
        step(1'b0, 1'b0, 9'h0, 1'b1);
        chk("coll_pc2", instr_pc, 9'h048);

        // PC wrap
        step(1'b0, 1'b1, 9'h1F8, 1'b1);
        step(1'b0, 1'b0, 9'h0, 1'b1);
        step(1'b0, 1'b0, 9'h0, 1'b1);
        chk("wrap_pc0", instr_pc, 9'h1F8);
        step(1'b0, 1'b0, 9'h0, 1'b1);
        chk("wrap_pc1", instr_pc, 9'h1FC);
        step(1'b0, 1'b0, 9'h0, 1'b1);
        chk("wrap_pc2", instr_pc, 9'h000);

        // One-cycle reset while full
        repeat (8) step(1'b0, 1'b0, 9'h0, 1'b0);
        chk("full_valid", instr_valid, 1'b1);
        reset = 1'b1;
        #1;
        chk("async_rst_valid", instr_valid, 1'b0);
        step(1'b1, 1'b0, 9'h0, 1'b1);
        step(1'b0, 1'b0, 9'h0, 1'b1);
        step(1'b0, 1'b0, 9'h0, 1'b1);
        chk("restart_valid", instr_valid, 1'b1);
        chk("restart_pc", instr_pc, 9'h000);

        // Randomized run against the model
        for (int n = 0; n < 800; n++) begin
            logic       r;
            logic       rd;
            logic       rdy;
            logic [8:0] rpc;
            r   = ($urandom_range(0, 99) < 1);
            rd  = !r && ($urandom_range(0, 99) < 6);
            rdy = ($urandom_range(0, 99) < 70);
            rpc = 9'($urandom_range(0, 127) * 4);
            step(r, rd, rpc, rdy);
        end
        step(1'b0, 1'b0, 9'h0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
